// File: rtl/tpu_pkg.sv
// Shared definitions for the MLP layer scheduler.
//   - scheduler FSM state encodings (also exported on sched_state_dbg)
//   - cfg_sel field selectors for the per-layer config table
//   - layer_cfg_t: one row of the per-layer norm/quant table
package tpu_pkg;

   typedef logic [3:0] sched_state_e;

   localparam sched_state_e S_IDLE   = 4'd0;
   localparam sched_state_e S_WRST   = 4'd1;
   localparam sched_state_e S_WLOAD  = 4'd2;
   localparam sched_state_e S_WREADY = 4'd3;
   localparam sched_state_e S_ACT    = 4'd4;
   localparam sched_state_e S_START  = 4'd5;
   localparam sched_state_e S_WAIT   = 4'd6;
   localparam sched_state_e S_NEXT   = 4'd7;
   localparam sched_state_e S_ERR    = 4'd8;
   localparam sched_state_e S_DONE   = 4'd9;

   localparam logic [2:0] CFG_GAIN  = 3'd0;
   localparam logic [2:0] CFG_BIAS  = 3'd1;
   localparam logic [2:0] CFG_SHIFT = 3'd2;
   localparam logic [2:0] CFG_INV   = 3'd3;
   localparam logic [2:0] CFG_ZP    = 3'd4;

   typedef struct packed {
      logic [15:0] gain;
      logic [31:0] bias;
      logic [4:0]  shift;
      logic [15:0] inv_scale;
      logic [7:0]  zero_point;
   } layer_cfg_t;

endpackage

// File: rtl/mlp_layer_scheduler_if.sv
// Bundle of all scheduler signals except clock/reset.
//   master: host + mlp_top + weight buffer side (drives cfg/job, wmem_rdata,
//           layer_complete, acc_*)
//   slave : the scheduler itself
interface mlp_layer_scheduler_if #(parameter int WMEM_AW = 5);
   logic               cfg_we;
   logic [1:0]         cfg_layer;
   logic [2:0]         cfg_sel;
   logic [31:0]        cfg_wdata;
   logic               job_start;
   logic [2:0]         job_num_layers;
   logic [15:0]        job_act_data;
   logic               job_abort;
   logic               busy;
   logic               job_done;
   logic               job_err;
   logic [31:0]        res_acc0;
   logic [31:0]        res_acc1;
   logic [WMEM_AW-1:0] wmem_addr;
   logic [7:0]         wmem_rdata;
   logic               wf_push_col0;
   logic               wf_push_col1;
   logic [7:0]         wf_data_in;
   logic               wf_reset;
   logic               init_act_valid;
   logic [15:0]        init_act_data;
   logic               start_mlp;
   logic               weights_ready;
   logic [15:0]        norm_gain;
   logic [31:0]        norm_bias;
   logic [4:0]         norm_shift;
   logic [15:0]        q_inv_scale;
   logic [7:0]         q_zero_point;
   logic               layer_complete;
   logic               acc_valid;
   logic [31:0]        acc0;
   logic [31:0]        acc1;
   logic [3:0]         sched_state_dbg;

   modport master (
      output cfg_we, cfg_layer, cfg_sel, cfg_wdata, job_start, job_num_layers,
             job_act_data, job_abort, wmem_rdata, layer_complete, acc_valid, acc0, acc1,
      input  busy, job_done, job_err, res_acc0, res_acc1, wmem_addr, wf_push_col0,
             wf_push_col1, wf_data_in, wf_reset, init_act_valid, init_act_data, start_mlp,
             weights_ready, norm_gain, norm_bias, norm_shift, q_inv_scale, q_zero_point,
             sched_state_dbg
   );

   modport slave (
      input  cfg_we, cfg_layer, cfg_sel, cfg_wdata, job_start, job_num_layers,
             job_act_data, job_abort, wmem_rdata, layer_complete, acc_valid, acc0, acc1,
      output busy, job_done, job_err, res_acc0, res_acc1, wmem_addr, wf_push_col0,
             wf_push_col1, wf_data_in, wf_reset, init_act_valid, init_act_data, start_mlp,
             weights_ready, norm_gain, norm_bias, norm_shift, q_inv_scale, q_zero_point,
             sched_state_dbg
   );
endinterface

// File: rtl/mlp_weight_streamer.sv
// Streams one layer's weight bytes from the weight buffer into the FIFOs.
//   start      : begin streaming layer `layer` (counter restarts)
//   kill       : stop immediately, no further pushes
//   wmem_addr  : layer*WBYTES + i, issued for i = 0..WBYTES-1
//   wmem_rdata : buffer data, one cycle after the address
//   push_col0/1, data_out : FIFO push strobes/data (first half col0, rest col1)
//   done       : high on the cycle carrying the last push
module mlp_weight_streamer #(
   parameter int WBYTES  = 4,
   parameter int WMEM_AW = 5
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic               kill,
   input  logic [2:0]         layer,
   output logic [WMEM_AW-1:0] wmem_addr,
   input  logic [7:0]         wmem_rdata,
   output logic               push_col0,
   output logic               push_col1,
   output logic [7:0]         data_out,
   output logic               done
);
   localparam int CW = $clog2(WBYTES + 1);

   logic          run_q, run_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [CW-1:0] idx;
   logic          push;

   // cnt_q is the address index; the byte pushed this cycle is for cnt_q-1
   // because the buffer returns data one cycle after the address.
   assign idx       = cnt_q - CW'(1);
   assign push      = run_q && (cnt_q != '0);
   assign done      = run_q && (cnt_q == CW'(WBYTES));
   assign push_col0 = push && (idx <  CW'(WBYTES / 2));
   assign push_col1 = push && (idx >= CW'(WBYTES / 2));
   assign data_out  = push ? wmem_rdata : 8'h00;
   assign wmem_addr = (run_q && cnt_q < CW'(WBYTES))
                      ? WMEM_AW'(int'(layer) * WBYTES) + WMEM_AW'(cnt_q) : '0;

   always_comb begin
      run_d = run_q;
      cnt_d = cnt_q;
      if (kill) begin
         run_d = 1'b0;
      end else if (start) begin
         run_d = 1'b1;
         cnt_d = '0;
      end else if (run_q) begin
         if (done) run_d = 1'b0;
         else      cnt_d = cnt_q + CW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         run_q <= 1'b0;
         cnt_q <= '0;
      end else begin
         run_q <= run_d;
         cnt_q <= cnt_d;
      end
   end
endmodule

// File: rtl/mlp_layer_scheduler.sv
// Job sequencer between the host command path and mlp_top.
//   clk, rst : clock, synchronous active-high reset
//   bus      : slave side of mlp_layer_scheduler_if -- config writes,
//              job_start/job_done handshake, weight buffer reads, FIFO pushes,
//              per-layer norm/quant outputs and mlp_top control/results.
// Holds the per-layer config table, loads each layer's weights via
// mlp_weight_streamer, starts the MLP on layer 0 and walks layers on
// layer_complete, with timeout and abort both ending in ERR -> DONE.
module mlp_layer_scheduler
   import tpu_pkg::*;
#(
   parameter int MAX_LAYERS       = 4,
   parameter int WBYTES_PER_LAYER = 4,
   parameter int WMEM_AW          = 5,
   parameter int TIMEOUT_CYCLES   = 1024
) (
   input  logic                  clk,
   input  logic                  rst,
   mlp_layer_scheduler_if.slave  bus
);
   localparam int LW = (MAX_LAYERS > 1) ? $clog2(MAX_LAYERS) : 1;
   localparam int TW = $clog2(TIMEOUT_CYCLES);

   sched_state_e state_q, state_d;
   logic [2:0]   layer_q, layer_d, num_q, num_d;
   logic [15:0]  act_q, act_d;
   logic         err_q, err_d, wrdy_q, wrdy_d;
   logic [TW-1:0] tmo_q, tmo_d;
   logic [31:0]  res0_q, res0_d, res1_q, res1_d;
   layer_cfg_t   norm_q, norm_d;
   layer_cfg_t   cfg_q [MAX_LAYERS];
   layer_cfg_t   cfg_d [MAX_LAYERS];
   logic         idle, abort, ws_done, num_ok;

   assign idle   = (state_q == S_IDLE);
   // Abort only means something while a job is still in flight.
   assign abort  = bus.job_abort && !idle && state_q != S_ERR && state_q != S_DONE;
   assign num_ok = (bus.job_num_layers != 3'd0) && (int'(bus.job_num_layers) <= MAX_LAYERS);

   // Config table; cfg_d is also the source for norm loads so a write in the
   // same cycle as job_start is seen by layer 0.
   always_comb begin
      cfg_d = cfg_q;
      if (bus.cfg_we && idle && int'(bus.cfg_layer) < MAX_LAYERS) begin
         case (bus.cfg_sel)
            CFG_GAIN:  cfg_d[bus.cfg_layer].gain       = bus.cfg_wdata[15:0];
            CFG_BIAS:  cfg_d[bus.cfg_layer].bias       = bus.cfg_wdata;
            CFG_SHIFT: cfg_d[bus.cfg_layer].shift      = bus.cfg_wdata[4:0];
            CFG_INV:   cfg_d[bus.cfg_layer].inv_scale  = bus.cfg_wdata[15:0];
            CFG_ZP:    cfg_d[bus.cfg_layer].zero_point = bus.cfg_wdata[7:0];
            default: ;
         endcase
      end
   end

   always_comb begin
      state_d = state_q;
      layer_d = layer_q;
      num_d   = num_q;
      act_d   = act_q;
      err_d   = err_q;
      wrdy_d  = wrdy_q;
      res0_d  = res0_q;
      res1_d  = res1_q;
      norm_d  = norm_q;
      tmo_d   = (state_q == S_WAIT) ? tmo_q + TW'(1) : '0;
      case (state_q)
         S_IDLE: if (bus.job_start) begin
            num_d   = bus.job_num_layers;
            act_d   = bus.job_act_data;
            layer_d = 3'd0;
            err_d   = !num_ok;
            if (num_ok) begin
               state_d = S_WRST;
               norm_d  = cfg_d[0];
            end else begin
               state_d = S_DONE;
            end
         end
         S_WRST:  state_d = S_WLOAD;
         S_WLOAD: if (ws_done) begin
            state_d = S_WREADY;
            wrdy_d  = 1'b1;
         end
         S_WREADY: state_d = (layer_q == 3'd0) ? S_ACT : S_WAIT;
         S_ACT:    state_d = S_START;
         S_START:  state_d = S_WAIT;
         S_WAIT: begin
            // Capture happens regardless of the transition taken below.
            if (bus.acc_valid) begin
               res0_d = bus.acc0;
               res1_d = bus.acc1;
            end
            if (bus.layer_complete) begin
               wrdy_d = 1'b0;
               if (layer_q == num_q - 3'd1) begin
                  state_d = S_DONE;
               end else begin
                  state_d = S_NEXT;
                  layer_d = layer_q + 3'd1;
               end
            end else if (tmo_q == TW'(TIMEOUT_CYCLES - 1)) begin
               state_d = S_ERR;
               wrdy_d  = 1'b0;
               err_d   = 1'b1;
            end
         end
         S_NEXT: begin
            state_d = S_WRST;
            norm_d  = cfg_d[layer_q[LW-1:0]];
         end
         S_ERR:  state_d = S_DONE;
         S_DONE: state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
      if (abort) begin
         state_d = S_ERR;
         wrdy_d  = 1'b0;
         err_d   = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         layer_q <= '0;
         num_q   <= '0;
         act_q   <= '0;
         err_q   <= 1'b0;
         wrdy_q  <= 1'b0;
         tmo_q   <= '0;
         res0_q  <= '0;
         res1_q  <= '0;
         norm_q  <= '0;
         for (int i = 0; i < MAX_LAYERS; i++) cfg_q[i] <= '0;
      end else begin
         state_q <= state_d;
         layer_q <= layer_d;
         num_q   <= num_d;
         act_q   <= act_d;
         err_q   <= err_d;
         wrdy_q  <= wrdy_d;
         tmo_q   <= tmo_d;
         res0_q  <= res0_d;
         res1_q  <= res1_d;
         norm_q  <= norm_d;
         for (int i = 0; i < MAX_LAYERS; i++) cfg_q[i] <= cfg_d[i];
      end
   end

   mlp_weight_streamer #(.WBYTES(WBYTES_PER_LAYER), .WMEM_AW(WMEM_AW)) u_ws (
      .clk        (clk),
      .rst        (rst),
      .start      (state_q == S_WRST),
      .kill       (abort),
      .layer      (layer_q),
      .wmem_addr  (bus.wmem_addr),
      .wmem_rdata (bus.wmem_rdata),
      .push_col0  (bus.wf_push_col0),
      .push_col1  (bus.wf_push_col1),
      .data_out   (bus.wf_data_in),
      .done       (ws_done)
   );

   assign bus.busy            = !idle;
   assign bus.job_done        = (state_q == S_DONE);
   assign bus.job_err         = (state_q == S_DONE) && err_q;
   assign bus.res_acc0        = res0_q;
   assign bus.res_acc1        = res1_q;
   assign bus.wf_reset        = (state_q == S_WRST) || (state_q == S_ERR);
   assign bus.init_act_valid  = (state_q == S_ACT);
   assign bus.init_act_data   = (state_q == S_ACT) ? act_q : 16'h0000;
   assign bus.start_mlp       = (state_q == S_START);
   assign bus.weights_ready   = wrdy_q;
   assign bus.norm_gain       = norm_q.gain;
   assign bus.norm_bias       = norm_q.bias;
   assign bus.norm_shift      = norm_q.shift;
   assign bus.q_inv_scale     = norm_q.inv_scale;
   assign bus.q_zero_point    = norm_q.zero_point;
   assign bus.sched_state_dbg = state_q;
endmodule
